seq_check_ctl: RTL and testbench

- Controller that sequences the 13-state unlock-sequence detector through a programmed 12-step input pattern.
- The detector's state codes are 0, 200, 700, 900, 1300, 1800, 2300, 2800, 3100, 3400, 3600, 3800 and 4100.
- The block holds a loadable pattern table and drives the detector inputs one step at a time. It checks the detector's state code after every step, retries failed attempts, and reports pass/fail with the failing step.
- It sits between the test/host logic and the detector, and owns the detector's reset and input pins.

---
 rtl/seq_check_ctl.sv | 221 ++++++++++++++++++++++
 tb/tb_seq_check_ctl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_check_ctl.sv
// seq_check_ctl: drives a 13-state unlock-sequence detector through a
// programmed pattern of up to 12 input vectors. After each step it compares
// the detector's state code to the hard-wired expected code. A mismatch
// triggers a retry, up to RETRY_MAX retries, and the final result is reported.
//
// Optional feature: define SEQCTL_TIMEOUT_EN to let CHECK wait while the
// detector still shows the previous step's code. The wait is bounded to
// TIMEOUT cycles. Without the macro, any non-matching code fails the step
// immediately.
//
// Ports:
//   clk, reset (async, active low)
//   load_valid/load_idx/load_vec - pattern table write (ignored while busy)
//   start                        - begin a run from IDLE
//   busy, done, pass             - run status; done is a 1-cycle pulse
//   fail_step, retries           - failing step (F on pass), retries used
//   det_rst, det_in              - detector reset (active high) and inputs
//   det_code                     - detector state code
module seq_check_ctl #(
  parameter int STEPS     = 12,
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [3:0]  load_idx,
  input  logic [3:0]  load_vec,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_step,
  output logic [1:0]  retries,
  output logic        det_rst,
  output logic [3:0]  det_in,
  input  logic [16:0] det_code
);

  typedef enum logic [2:0] {S_IDLE, S_RST_DET, S_DRIVE, S_CHECK, S_FAIL, S_DONE} state_t;

  function automatic logic [16:0] exp_code(input logic [3:0] i);
    case (i)
      4'd0:    exp_code = 17'd0;
      4'd1:    exp_code = 17'd200;
      4'd2:    exp_code = 17'd700;
      4'd3:    exp_code = 17'd900;
      4'd4:    exp_code = 17'd1300;
      4'd5:    exp_code = 17'd1800;
      4'd6:    exp_code = 17'd2300;
      4'd7:    exp_code = 17'd2800;
      4'd8:    exp_code = 17'd3100;
      4'd9:    exp_code = 17'd3400;
      4'd10:   exp_code = 17'd3600;
      4'd11:   exp_code = 17'd3800;
      4'd12:   exp_code = 17'd4100;
      default: exp_code = 17'd0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [1:0]        rcnt_q, rcnt_d;
  logic [11:0][3:0]  tbl_q, tbl_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]        fail_step_q, fail_step_d;
  logic [1:0]        retries_q, retries_d;
  logic              det_rst_q, det_rst_d;
  logic [3:0]        det_in_q, det_in_d;
  logic [3:0]        k_inc;
  logic              code_ok;
`ifdef SEQCTL_TIMEOUT_EN
  logic [3:0]        stall_q, stall_d;
  logic              code_hold;
`endif

  assign k_inc   = k_q + 4'd1;
  assign code_ok = (det_code == exp_code(k_inc));
`ifdef SEQCTL_TIMEOUT_EN
  // Detector still sitting on the previous step's code: it may just be slow.
  assign code_hold = (det_code == exp_code(k_q));
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rcnt_d      = rcnt_q;
    tbl_d       = tbl_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_step_d = fail_step_q;
    retries_d   = retries_q;
    det_rst_d   = det_rst_q;
    det_in_d    = det_in_q;
`ifdef SEQCTL_TIMEOUT_EN
    stall_d     = stall_q;
`endif

    // Table writes are applied before start is acted on, so a same-cycle
    // load is seen by the run that start launches.
    if (load_valid && !busy_q && load_idx < 4'd12)
      tbl_d[load_idx] = load_vec;

    case (state_q)
      S_IDLE: begin
        det_rst_d = 1'b1;
        det_in_d  = 4'd0;
        if (start) begin
          state_d     = S_RST_DET;
          rcnt_d      = 2'd2;  // first attempt: one clearing cycle plus 2 reset cycles
          busy_d      = 1'b1;
          retries_d   = 2'd0;
          pass_d      = 1'b0;
          fail_step_d = 4'hF;
        end
      end
      S_RST_DET: begin
        if (rcnt_q == 2'd0) begin
          state_d   = S_DRIVE;
          k_d       = 4'd0;
          det_rst_d = 1'b0;
          det_in_d  = tbl_q[0];
        end else begin
          rcnt_d = rcnt_q - 2'd1;
        end
      end
      S_DRIVE: begin
        state_d = S_CHECK;
`ifdef SEQCTL_TIMEOUT_EN
        stall_d = 4'd0;
`endif
      end
      S_CHECK: begin
        if (code_ok) begin
          if (k_q == 4'(STEPS - 1)) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            pass_d      = 1'b1;
            fail_step_d = 4'hF;
            det_rst_d   = 1'b1;
            det_in_d    = 4'd0;
          end else begin
            state_d  = S_DRIVE;
            k_d      = k_inc;
            det_in_d = tbl_q[k_inc];
          end
        end
`ifdef SEQCTL_TIMEOUT_EN
        else if (code_hold && stall_q != 4'(TIMEOUT)) begin
          stall_d = stall_q + 4'd1;
        end
`endif
        else begin
          state_d     = S_FAIL;
          fail_step_d = k_q;
          det_rst_d   = 1'b1;
          det_in_d    = 4'd0;
        end
      end
      S_FAIL: begin
        if (retries_q < 2'(RETRY_MAX)) begin
          state_d   = S_RST_DET;
          rcnt_d    = 2'd1;
          retries_d = retries_q + 2'd1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      k_q         <= 4'd0;
      rcnt_q      <= 2'd0;
      tbl_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_step_q <= 4'hF;
      retries_q   <= 2'd0;
      det_rst_q   <= 1'b1;
      det_in_q    <= 4'd0;
`ifdef SEQCTL_TIMEOUT_EN
      stall_q     <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      rcnt_q      <= rcnt_d;
      tbl_q       <= tbl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_step_q <= fail_step_d;
      retries_q   <= retries_d;
      det_rst_q   <= det_rst_d;
      det_in_q    <= det_in_d;
`ifdef SEQCTL_TIMEOUT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_step = fail_step_q;
  assign retries   = retries_q;
  assign det_rst   = det_rst_q;
  assign det_in    = det_in_q;

endmodule

// File: tb/tb_seq_check_ctl.sv
// Bench for seq_check_ctl: a behavioural detector model with fault and stall
// injection, a table of run scenarios, and a scoreboard queue of expected
// results checked against each done pulse.
module tb_seq_check_ctl;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, start;
  logic [3:0]  load_idx, load_vec;
  logic        busy, done, pass, det_rst;
  logic [3:0]  fail_step, det_in;
  logic [1:0]  retries;
  logic [16:0] det_code;

  always #5 clk = ~clk;

  seq_check_ctl dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_idx(load_idx),
    .load_vec(load_vec), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_step(fail_step), .retries(retries), .det_rst(det_rst), .det_in(det_in),
    .det_code(det_code)
  );

  localparam logic [3:0]  PAT [12] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd5,
                                       4'd9, 4'd6, 4'd10, 4'd12, 4'd7, 4'd11};
  localparam logic [16:0] EXP [13] = '{17'd0, 17'd200, 17'd700, 17'd900, 17'd1300,
                                       17'd1800, 17'd2300, 17'd2800, 17'd3100,
                                       17'd3400, 17'd3600, 17'd3800, 17'd4100};

  // ---------------- detector model ----------------
  // Advances one state on each change of det_in that matches the pattern;
  // any other change drops it back to state 0.
  int         idx = 0, hold_cnt = 0, fault_hits = 0;
  int         stall_len = 0, fault_step = 0, fault_cnt = 0;
  logic [3:0] prev_in = 4'd0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin : mdl
    logic ok;
    if (!busy) fault_hits <= 0;
    if (det_rst) begin
      idx <= 0; prev_in <= 4'd0; hold_cnt <= 0;
    end else begin
      if (idx == 6 && hold_cnt < stall_len) hold_cnt <= hold_cnt + 1;
      if (det_in != prev_in) begin
        prev_in <= det_in;
        ok = (idx < 12) && (det_in == PAT[idx]);
        if (ok && idx == fault_step && fault_hits < fault_cnt) begin
          ok = 1'b0;
          fault_hits <= fault_hits + 1;
        end
        idx <= ok ? idx + 1 : 0;
      end
    end
  end

  always_comb begin
    det_code = (idx <= 12) ? EXP[idx] : 17'd0;
    if (idx == 6 && hold_cnt < stall_len) det_code = EXP[5];
  end

  // ---------------- checking ----------------
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       p;
    logic [3:0] fs;
    logic [1:0] rt;
    int         lat;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string      name;
    int         bad_idx;     // -1: table left correct
    logic [3:0] bad_vec;
    bit         fix_at_start;// reload the correct vector in the start cycle
    bit         poke;        // load and start pulsed while busy
    int         f_step, f_cnt, s_len;
    logic       p;
    logic [3:0] fs;
    logic [1:0] rt;
    int         lat;
  } vec_t;

  task automatic load(input int i, input logic [3:0] v);
    @(negedge clk);
    load_valid = 1'b1; load_idx = 4'(i); load_vec = v;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 12; i++) load(i, PAT[i]);
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int   n0;
    bit   got;
    stall_len = v.s_len; fault_step = v.f_step; fault_cnt = v.f_cnt;
    if (v.bad_idx >= 0) load(v.bad_idx, v.bad_vec);
    e.p = v.p; e.fs = v.fs; e.rt = v.rt; e.lat = v.lat;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b1;
    if (v.fix_at_start) begin
      load_valid = 1'b1; load_idx = 4'(v.bad_idx); load_vec = PAT[v.bad_idx];
    end
    n0 = cyc;
    got = 1'b0;
    for (int i = 1; i <= 400 && !got; i++) begin
      @(negedge clk);
      start = 1'b0; load_valid = 1'b0;
      if (i == 1) chk({v.name, "_busy"}, busy, 1);
      if (v.poke && i == 6) begin
        start = 1'b1; load_valid = 1'b1; load_idx = 4'd0; load_vec = 4'hF;
      end
      if (done) begin
        got = 1'b1;
        e = sbq.pop_front();
        chk({v.name, "_latency"}, cyc - n0, e.lat);
        chk({v.name, "_pass"}, pass, e.p);
        chk({v.name, "_fail_step"}, fail_step, e.fs);
        chk({v.name, "_retries"}, retries, e.rt);
        chk({v.name, "_busy_at_done"}, busy, 0);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got no done expected done", v.name);
      void'(sbq.pop_front());
    end
    @(negedge clk);
    chk({v.name, "_done_pulse"}, done, 0);
    chk({v.name, "_idle_after"}, busy, 0);
    stall_len = 0; fault_cnt = 0;
    if (v.bad_idx >= 0 && !v.fix_at_start) load(v.bad_idx, PAT[v.bad_idx]);
  endtask

  vec_t vt[$];
  vec_t clean;
  int   ndone;

  initial begin
    reset = 1'b0; load_valid = 1'b0; start = 1'b0; load_idx = 4'd0; load_vec = 4'd0;
    clean = '{"clean", -1, 4'h0, 0, 0, 0, 0, 0, 1'b1, 4'hF, 2'd0, 28};

    // Reset values
    #12;
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);      chk("rst_fail_step", fail_step, 4'hF);
    chk("rst_retries", retries, 0); chk("rst_det_rst", det_rst, 1);
    chk("rst_det_in", det_in, 0);
    @(negedge clk); reset = 1'b1;
    load_all();

    vt.push_back(clean);
    vt.push_back('{"persist3", 3, 4'hF, 0, 0, 0, 0, 0, 1'b0, 4'd3, 2'd3, 46});
    vt.push_back('{"persist11", 11, 4'hF, 0, 0, 0, 0, 0, 1'b0, 4'd11, 2'd3, 110});
    vt.push_back('{"transient4", -1, 4'h0, 0, 0, 4, 1, 0, 1'b1, 4'hF, 2'd1, 41});
    vt.push_back('{"transient0", -1, 4'h0, 0, 0, 0, 1, 0, 1'b1, 4'hF, 2'd1, 33});
    vt.push_back('{"transient11x2", -1, 4'h0, 0, 0, 11, 2, 0, 1'b1, 4'hF, 2'd2, 82});
    vt.push_back('{"busy_poke", -1, 4'h0, 0, 1, 0, 0, 0, 1'b1, 4'hF, 2'd0, 28});
    vt.push_back(clean);
    vt.push_back('{"load_with_start", 2, 4'hF, 1, 0, 0, 0, 0, 1'b1, 4'hF, 2'd0, 28});
`ifdef SEQCTL_TIMEOUT_EN
    vt.push_back('{"stall5", -1, 4'h0, 0, 0, 0, 0, 5, 1'b1, 4'hF, 2'd0, 33});
    vt.push_back('{"stall9", -1, 4'h0, 0, 0, 0, 0, 9, 1'b0, 4'd5, 2'd3, 94});
`else
    vt.push_back('{"stall5", -1, 4'h0, 0, 0, 0, 0, 5, 1'b0, 4'd5, 2'd3, 62});
    vt.push_back('{"stall9", -1, 4'h0, 0, 0, 0, 0, 9, 1'b0, 4'd5, 2'd3, 62});
`endif
    foreach (vt[i]) run(vt[i]);

    // Out-of-range index must not touch the table
    load(13, 4'hF);
    clean.name = "idx13";
    run(clean);

    // Reset in the middle of step 5: immediate reset values, no done pulse
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);       chk("midrst_pass", pass, 0);
    chk("midrst_fail_step", fail_step, 4'hF); chk("midrst_retries", retries, 0);
    chk("midrst_det_rst", det_rst, 1); chk("midrst_det_in", det_in, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    chk("midrst_no_done", ndone, 0);
    load_all();
    clean.name = "after_reset";
    run(clean);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
